// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle for the sequential shift-add multiplier.
// The requester drives operands/controls; the multiplier returns the result and status.
interface seq_multiplier_if #(
    parameter int WA = 16,
    parameter int WB = 9
);
    logic [WA-1:0] A;
    logic [WB-1:0] B;
    logic          REQ;
    logic          ABORT;
    logic [WA-1:0] PROD;
    logic          ACK;
    logic          BUSY;
    logic          OVF;

    modport master (
        output A, B, REQ, ABORT,
        input  PROD, ACK, BUSY, OVF
    );

    modport slave (
        input  A, B, REQ, ABORT,
        output PROD, ACK, BUSY, OVF
    );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one multiplier bit per RUN cycle (WB cycles),
// truncated product plus overflow flag registered on entry to DONE.
module seq_multiplier #(
    parameter int WA = 16,
    parameter int WB = 9
) (
    input  logic            CLK,
    input  logic            RST,
    seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WB + 1);
    localparam int WP = WA + WB;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [WP-1:0]  mcand_q, mcand_d;
    logic [WP-1:0]  acc_q, acc_d;
    logic [WB-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WA-1:0]  prod_q, prod_d;
    logic           ovf_q, ovf_d;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; ABORT overrides everything, including RUN completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.REQ) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.ABORT) state_d = S_IDLE;
    end

    // Output decode from the registered state
    always_comb begin
        bus.ACK  = (state_q == S_DONE);
        bus.BUSY = (state_q != S_IDLE);
        bus.PROD = prod_q;
        bus.OVF  = ovf_q;
    end

    // Datapath next values
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    mcand_d  = {{WB{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = CW'(WB);
                end
            end
            S_RUN: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
            end
            default: ;
        endcase
        // Result captures the final partial sum of the same edge that enters DONE
        if (state_q == S_RUN && state_d == S_DONE) begin
            prod_d = acc_d[WA-1:0];
            ovf_d  = |acc_d[WP-1:WA];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier against an arithmetic product model.
module tb_seq_multiplier;
    localparam int WA = 16;
    localparam int WB = 9;
    localparam int LAT = WB + 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_multiplier_if #(.WA(WA), .WB(WB)) bus ();

    seq_multiplier #(.WA(WA), .WB(WB)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WA-1:0] model_prod(input logic [WA-1:0] a, input logic [WB-1:0] b);
        longint full;
        full = longint'(a) * longint'(b);
        return WA'(full % (longint'(1) << WA));
    endfunction

    function automatic logic model_ovf(input logic [WA-1:0] a, input logic [WB-1:0] b);
        longint full;
        full = longint'(a) * longint'(b);
        return full > ((longint'(1) << WA) - 1);
    endfunction

    // One request; returns observations (comparisons are made by the callers)
    task automatic run_op(input logic [WA-1:0] a, input logic [WB-1:0] b,
                          output int lat, output logic [WA-1:0] p, output logic o,
                          output logic busy1, output logic held, output logic single);
        logic [WA-1:0] p0;
        p0 = bus.PROD;
        held = 1'b1;
        busy1 = 1'b0;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.REQ = 1'b1;
        @(posedge clk);
        #1;
        bus.REQ = 1'b0;
        bus.A = WA'($urandom);
        bus.B = WB'($urandom);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) busy1 = bus.BUSY;
            if (bus.ACK) begin
                lat = i;
                break;
            end
            if (bus.PROD !== p0) held = 1'b0;
        end
        p = bus.PROD;
        o = bus.OVF;
        @(negedge clk);
        single = !bus.ACK && !bus.BUSY;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.A = '0; bus.B = '0; bus.REQ = 1'b0; bus.ABORT = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.PROD !== '0 || bus.OVF !== 1'b0 || bus.ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got prod=%0d ovf=%b ack=%b busy=%b, want all 0",
                     bus.PROD, bus.OVF, bus.ACK, bus.BUSY);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic [WA-1:0] p; logic o, b1, held, single;
        run_op(16'd5, 9'd24, lat, p, o, b1, held, single);
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", b1); end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (p !== 16'd120 || o !== 1'b0) begin
            errors++; $display("FAIL basic_result: got prod=%0d ovf=%b want 120/0", p, o);
        end
        checks++;
        if (single !== 1'b1) begin errors++; $display("FAIL basic_ack_single: ack not a one-cycle pulse"); end
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL basic_prod_hold: prod changed during run"); end
    endtask

    task automatic test_vectors();
        logic [WA-1:0] va [6];
        logic [WB-1:0] vb [6];
        logic [WA-1:0] ep [6];
        logic          eo [6];
        int lat; logic [WA-1:0] p; logic o, b1, held, single;
        va = '{16'd40320, 16'd5040, 16'd300, 16'd65535, 16'd0, 16'd65535};
        vb = '{9'd9, 9'd8, 9'd300, 9'd1, 9'd511, 9'd511};
        ep = '{16'd35200, 16'd40320, 16'd24464, 16'd65535, 16'd0, model_prod(16'd65535, 9'd511)};
        eo = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], lat, p, o, b1, held, single);
            checks++;
            if (p !== ep[i] || o !== eo[i]) begin
                errors++;
                $display("FAIL vector_%0d: %0d*%0d got prod=%0d ovf=%b want %0d/%b",
                         i, va[i], vb[i], p, o, ep[i], eo[i]);
            end
            checks++;
            if (lat != LAT || single !== 1'b1) begin
                errors++; $display("FAIL vector_%0d_timing: latency %0d single=%b want %0d/1", i, lat, single, LAT);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [WA-1:0] p; logic o, b1, held, single;
        logic [WA-1:0] a; logic [WB-1:0] b;
        for (int i = 0; i < 30; i++) begin
            a = WA'($urandom);
            b = WB'($urandom);
            run_op(a, b, lat, p, o, b1, held, single);
            checks++;
            if (p !== model_prod(a, b) || o !== model_ovf(a, b) || lat != LAT || held !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d: %0d*%0d got prod=%0d ovf=%b lat=%0d held=%b want %0d/%b/%0d/1",
                         i, a, b, p, o, lat, held, model_prod(a, b), model_ovf(a, b), LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks, last, gap_bad, prod_bad;
        acks = 0; last = -1; gap_bad = 0; prod_bad = 0;
        @(negedge clk);
        bus.A = 16'd3; bus.B = 9'd4; bus.REQ = 1'b1;
        for (int i = 1; i <= 60 && acks < 4; i++) begin
            @(negedge clk);
            if (bus.ACK) begin
                acks++;
                if (bus.PROD !== 16'd12) prod_bad++;
                if (last >= 0 && i - last != LAT + 1) gap_bad++;
                last = i;
                bus.A = 16'd3; bus.B = 9'd4;
                if (acks == 4) bus.REQ = 1'b0;
            end else if (bus.BUSY) begin
                bus.A = WA'($urandom); bus.B = WB'($urandom);
            end
        end
        checks++;
        if (acks != 4) begin errors++; $display("FAIL b2b_ack_count: got %0d want 4", acks); end
        checks++;
        if (gap_bad != 0) begin errors++; $display("FAIL b2b_period: %0d gaps differ from %0d", gap_bad, LAT + 1); end
        checks++;
        if (prod_bad != 0) begin errors++; $display("FAIL b2b_prod: %0d results not 12", prod_bad); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, stray; logic [WA-1:0] p; logic o, b1, held, single;
        run_op(16'd7, 9'd6, lat, p, o, b1, held, single);
        checks++;
        if (p !== 16'd42) begin errors++; $display("FAIL rstmid_setup: got %0d want 42", p); end
        @(negedge clk);
        bus.A = 16'd100; bus.B = 9'd200; bus.REQ = 1'b1;
        @(posedge clk);
        #1 bus.REQ = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.PROD !== '0 || bus.OVF !== 1'b0 || bus.ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got prod=%0d ovf=%b ack=%b busy=%b want all 0",
                     bus.PROD, bus.OVF, bus.ACK, bus.BUSY);
        end
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.ACK || bus.BUSY) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rstmid_no_ack: %0d cycles with ack/busy want 0", stray); end
        run_op(16'd11, 9'd13, lat, p, o, b1, held, single);
        checks++;
        if (lat != LAT || p !== 16'd143) begin
            errors++; $display("FAIL rstmid_first_req: lat=%0d prod=%0d want %0d/143", lat, p, LAT);
        end
    endtask

    task automatic test_abort();
        int lat, stray; logic [WA-1:0] p; logic o, b1, held, single;
        run_op(16'd7, 9'd6, lat, p, o, b1, held, single);
        // abort mid-run, then abort on the completing edge
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.A = 16'd100; bus.B = 9'd200; bus.REQ = 1'b1;
            @(posedge clk);
            #1 bus.REQ = 1'b0;
            repeat (k == 0 ? 5 : WB) @(negedge clk);
            checks++;
            if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL abort_%0d_prebusy: got %b want 1", k, bus.BUSY); end
            bus.ABORT = 1'b1;
            @(negedge clk);
            bus.ABORT = 1'b0;
            checks++;
            if (bus.BUSY !== 1'b0 || bus.ACK !== 1'b0 || bus.PROD !== 16'd42 || bus.OVF !== 1'b0) begin
                errors++;
                $display("FAIL abort_%0d_state: busy=%b ack=%b prod=%0d ovf=%b want 0/0/42/0",
                         k, bus.BUSY, bus.ACK, bus.PROD, bus.OVF);
            end
            stray = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.ACK) stray++;
            end
            checks++;
            if (stray != 0) begin errors++; $display("FAIL abort_%0d_no_ack: got %0d acks want 0", k, stray); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
